team_06_soft_clip_stage: RTL and testbench

Parametrised, pipelined soft/hard clipping stage for the team_06 audio path. It sits between the effect chain and the output formatter and accepts one unsigned sample per `valid_in` strobe. Each sample passes through one of three modes: bypass, soft-knee compression with a programmable knee, ceiling and slope, or hard clamp. It also keeps a saturating clip counter and a retriggerable clip-indicator hold timer, and its reset configuration reproduces the team's fixed 180/220 soft clipper.

---
 rtl/team_06_soft_clip_stage.sv | 101 ++++++++++
 tb/tb_team_06_soft_clip_stage.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/team_06_soft_clip_stage.sv
// team_06_soft_clip_stage: two-stage pipelined bypass/soft-knee/hard clipper with clip counter and LED hold timer
// Ports: clk, nrst (async active-low); valid_in/audio_in sample input;
//        cfg_load latches cfg_mode/cfg_knee/cfg_ceiling/cfg_shift into shadow config;
//        clear_count clears clip_count; valid_out/soft_out processed sample;
//        clip_led held clip indicator; clip_count saturating clipped-sample count.
module team_06_soft_clip_stage #(
  parameter int WIDTH       = 8,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 1024,
  parameter int KNEE_RST    = 180,
  parameter int CEIL_RST    = 220
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] audio_in,
  input  logic             cfg_load,
  input  logic [1:0]       cfg_mode,
  input  logic [WIDTH-1:0] cfg_knee,
  input  logic [WIDTH-1:0] cfg_ceiling,
  input  logic [1:0]       cfg_shift,
  input  logic             clear_count,
  output logic             valid_out,
  output logic [WIDTH-1:0] soft_out,
  output logic             clip_led,
  output logic [CNT_W-1:0] clip_count
);
  localparam int TW = $clog2(HOLD_CYCLES + 1);
  logic [1:0]       mode_q, shift_q, mode1_q, shift1_q;
  logic [WIDTH-1:0] knee_q, ceil_q, x1_q, knee1_q, ceil1_q, y_q, hard_y, y_d;
  logic [WIDTH:0]   d1_q, sum;
  logic             v1_q, vo_q, clip2_q, hard_clip, over, clip_d, clip_evt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  assign valid_out  = vo_q;
  assign soft_out   = y_q;
  assign clip_count = cnt_q;
  assign clip_led   = tmr_q != '0;
  assign clip_evt   = vo_q && clip2_q;
  // Stage 2: mode 2 and a knee at/above the ceiling both collapse to a plain clamp
  always_comb begin
    hard_clip = x1_q > ceil1_q;
    hard_y    = hard_clip ? ceil1_q : x1_q;
    over      = x1_q > knee1_q;
    sum       = {1'b0, knee1_q} + (d1_q >> shift1_q);
    y_d       = (mode1_q == 2'b00) ? x1_q :
                (mode1_q == 2'b10 || knee1_q >= ceil1_q) ? hard_y :
                !over ? x1_q :
                (sum > {1'b0, ceil1_q}) ? ceil1_q : sum[WIDTH-1:0];
    clip_d    = (mode1_q == 2'b00) ? 1'b0 :
                (mode1_q == 2'b10 || knee1_q >= ceil1_q) ? hard_clip : over;
    cnt_d     = clear_count ? '0 :
                (clip_evt && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    tmr_d     = clip_evt ? TW'(HOLD_CYCLES) :
                (tmr_q != '0) ? tmr_q - TW'(1) : tmr_q;
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode_q   <= 2'b01;
      knee_q   <= WIDTH'(KNEE_RST);
      ceil_q   <= WIDTH'(CEIL_RST);
      shift_q  <= 2'd1;
      v1_q     <= 1'b0;
      x1_q     <= '0;
      knee1_q  <= '0;
      ceil1_q  <= '0;
      mode1_q  <= '0;
      shift1_q <= '0;
      d1_q     <= '0;
      vo_q     <= 1'b0;
      y_q      <= '0;
      clip2_q  <= 1'b0;
      cnt_q    <= '0;
      tmr_q    <= '0;
    end else begin
      if (cfg_load) begin
        mode_q  <= cfg_mode;
        knee_q  <= cfg_knee;
        ceil_q  <= cfg_ceiling;
        shift_q <= cfg_shift;
      end
      v1_q <= valid_in;
      // each sample carries the config it was captured with
      if (valid_in) begin
        x1_q     <= audio_in;
        knee1_q  <= knee_q;
        ceil1_q  <= ceil_q;
        mode1_q  <= mode_q;
        shift1_q <= shift_q;
        d1_q     <= {1'b0, audio_in} - {1'b0, knee_q};
      end
      vo_q <= v1_q;
      if (v1_q) begin
        y_q     <= y_d;
        clip2_q <= clip_d;
      end
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
    end
  end
endmodule

// File: tb/tb_team_06_soft_clip_stage.sv
// tb_team_06_soft_clip_stage: directed plus random check of the clip stage against a behavioural model
module tb_team_06_soft_clip_stage;
  localparam int HOLD = 8;
  localparam int CMAX = 15;
  logic       clk = 0, nrst = 0, valid_in = 0, cfg_load = 0, clear_count = 0;
  logic [7:0] audio_in = 0, cfg_knee = 0, cfg_ceiling = 0;
  logic [1:0] cfg_mode = 0, cfg_shift = 0;
  logic       valid_out, clip_led;
  logic [7:0] soft_out;
  logic [3:0] clip_count;
  typedef struct { int due; int y; bit clip; } exp_t;
  exp_t q[$];
  int cyc = 0, cnt = 0, tmr = 0, last_y = 0, total = 0, bad = 0;
  int m_mode = 1, m_knee = 180, m_ceil = 220, m_shift = 1;
  bit prev_clip = 0, cur_v = 0;
  team_06_soft_clip_stage #(.WIDTH(8), .CNT_W(4), .HOLD_CYCLES(HOLD), .KNEE_RST(180), .CEIL_RST(220)) dut (
    .clk(clk), .nrst(nrst), .valid_in(valid_in), .audio_in(audio_in),
    .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_knee(cfg_knee),
    .cfg_ceiling(cfg_ceiling), .cfg_shift(cfg_shift), .clear_count(clear_count),
    .valid_out(valid_out), .soft_out(soft_out), .clip_led(clip_led), .clip_count(clip_count)
  );
  always #5 clk = ~clk;
  function automatic void ref_out(input int x, input int m, input int k, input int c, input int s,
                                  output int y, output bit cl);
    if (m == 0) begin
      y = x; cl = 0;
    end else if (m == 2 || k >= c) begin
      cl = x > c; y = cl ? c : x;
    end else if (x <= k) begin
      y = x; cl = 0;
    end else begin
      y = k + (x - k) / (1 << s);
      if (y > c) y = c;
      cl = 1;
    end
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask
  task automatic setcfg(input int m, input int k, input int c, input int s);
    cfg_mode = 2'(m); cfg_knee = 8'(k); cfg_ceiling = 8'(c); cfg_shift = 2'(s);
  endtask
  task automatic model_reset();
    q.delete();
    cnt = 0; tmr = 0; last_y = 0; prev_clip = 0; cur_v = 0;
    m_mode = 1; m_knee = 180; m_ceil = 220; m_shift = 1;
  endtask
  task automatic tick(input bit vin, input int x, input bit ld, input bit clr);
    exp_t e;
    int y;
    bit cl;
    valid_in = vin; audio_in = 8'(x); cfg_load = ld; clear_count = clr;
    @(posedge clk);
    cyc++;
    if (clr) cnt = 0; else if (prev_clip && cnt < CMAX) cnt++;
    if (prev_clip) tmr = HOLD; else if (tmr > 0) tmr--;
    if (vin) begin
      ref_out(x, m_mode, m_knee, m_ceil, m_shift, y, cl);
      e.due = cyc + 1; e.y = y; e.clip = cl;
      q.push_back(e);
    end
    if (ld) begin
      m_mode = int'(cfg_mode); m_knee = int'(cfg_knee);
      m_ceil = int'(cfg_ceiling); m_shift = int'(cfg_shift);
    end
    cur_v = 0; prev_clip = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      cur_v = 1; last_y = e.y; prev_clip = e.clip;
    end
    #1;
    chk("valid_out", valid_out, int'(cur_v));
    chk("soft_out", soft_out, last_y);
    chk("clip_count", clip_count, cnt);
    chk("clip_led", clip_led, int'(tmr != 0));
    valid_in = 0; cfg_load = 0; clear_count = 0;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
  endtask
  initial begin
    int tv[5] = '{100, 180, 200, 220, 250};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", valid_out, 0);
    chk("rst_soft", soft_out, 0);
    chk("rst_led", clip_led, 0);
    chk("rst_cnt", clip_count, 0);
    @(negedge clk) nrst = 1;
    for (int i = 0; i < 5; i++) tick(1, tv[i], 0, 0);
    idle(3);
    chk("soft_cnt3", clip_count, 3);
    setcfg(2, 180, 200, 1);
    tick(1, 230, 1, 0);
    tick(1, 230, 0, 0);
    tick(1, 150, 0, 0);
    setcfg(1, 100, 255, 2);
    tick(0, 0, 1, 0);
    tick(1, 200, 0, 0);
    idle(2);
    setcfg(0, 100, 255, 2);
    tick(0, 0, 1, 0);
    tick(1, 255, 0, 0);
    idle(3);
    setcfg(1, 240, 200, 1);
    tick(0, 0, 1, 0);
    tick(1, 220, 0, 0);
    tick(1, 199, 0, 0);
    idle(3);
    setcfg(2, 0, 200, 0);
    tick(0, 0, 1, 1);
    for (int i = 0; i < 20; i++) tick(1, 250, 0, 0);
    idle(3);
    chk("sat15", clip_count, CMAX);
    tick(1, 250, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    chk("clr_wins", clip_count, 0);
    idle(12);
    tick(1, 250, 0, 0);
    idle(12);
    tick(1, 250, 0, 0);
    idle(5);
    tick(1, 250, 0, 0);
    idle(12);
    for (int i = 0; i < 300; i++) begin
      bit ld;
      ld = $urandom_range(0, 15) == 0;
      if (ld) setcfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 255), ld, $urandom_range(0, 31) == 0);
    end
    setcfg(2, 0, 100, 0);
    tick(0, 0, 1, 0);
    tick(1, 200, 0, 0);
    tick(1, 250, 0, 0);
    #2 nrst = 0;
    #1;
    model_reset();
    chk("arst_valid", valid_out, 0);
    chk("arst_soft", soft_out, 0);
    chk("arst_led", clip_led, 0);
    chk("arst_cnt", clip_count, 0);
    #2 nrst = 1;
    idle(4);
    tick(1, 200, 0, 0);
    idle(2);
    chk("arst_cfg", soft_out, 190);
    idle(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
